formacao_ctrl: RTL
==================

// Module: formacao_ctrl
// PURPOSE
//  Central sequencer for the enemy formation. Divides CLOCK_50 into movement steps and holds one shared direction.
//  Issues single-cycle step/descend commands to every enemy instance, so the formation turns as a unit at the screen edges.
//  Speeds the formation up as enemies die; flags wave cleared and invasion (enemy reached the player line) to game control.
// PARAMETERS
//  N_INIM     8       number of enemies handled
//  DIV_BASE   320000  CLOCK_50 cycles per step with all enemies alive
//  DIV_DEC    30000   cycles removed from the period per dead enemy
//  DIV_MIN    80000   floor of the step period
//  LARGURA    33      enemy sprite width (px)
//  ALTURA     24      enemy sprite height (px)
//  TELA_W     640     screen width (px)
//  PASSO_X    2       horizontal step (px)
//  LIMITE_Y   440     invasion line (px)
// PORTS
//  CLOCK_50     in   1         system clock
//  resetInimigo in   1         async active-high reset (reset || reiniciarJogo)
//  pausa        in   1         1 = freeze divider and FSM
//  vivo         in   N_INIM    per-enemy alive flags
//  x_flat       in   10*N_INIM enemy i x at [10i+9:10i]
//  y_flat       in   10*N_INIM enemy i y at [10i+9:10i]
//  passo        out  1         1-cycle pulse: every enemy moves PASSO_X toward sentido
//  descer       out  1         1-cycle pulse: every enemy moves down; no horizontal move on this step
//  sentido      out  1         1 = right, 0 = left
//  fim_onda     out  1         sticky: all enemies dead
//  invasao      out  1         sticky: an alive enemy touched LIMITE_Y
//  n_mortos     out  4         count of dead enemies (saturating, registered)
// BEHAVIOUR
//  Reset: passo=0, descer=0, sentido=0, fim_onda=0, invasao=0, n_mortos=0, divider=0, state=ESPERA.
//  Period P = max(DIV_MIN, DIV_BASE - DIV_DEC*n_mortos); compute in 32-bit unsigned, no underflow.
//  ESPERA:   divider++ every cycle while pausa=0; at divider>=P-1 -> AVALIA, divider=0.
//  AVALIA:   one cycle; evaluate alive enemies only.
//   - borda = (sentido && any x+LARGURA+PASSO_X > TELA_W) || (!sentido && any x < PASSO_X).
//   - borda -> DESCE; else -> MOVE.
//  MOVE:     passo=1 for exactly one cycle -> ESPERA.
//  DESCE:    descer=1 for one cycle; sentido toggles in the same cycle -> ESPERA.
//  Step period: one step every P+1 cycles (AVALIA/MOVE or DESCE add no idle cycles beyond that).
//  n_mortos: recomputed every cycle as the popcount of ~vivo.
//  fim_onda: set when vivo==0; invasao: set when any alive y+ALTURA >= LIMITE_Y.
//   - Either flag set -> FIM: no passo/descer until reset.
//   - Both conditions in the same cycle -> both flags set.
//  pausa=1: divider and state hold; passo/descer forced to 0; fim_onda/invasao detection continues.
//  Reset asserted mid-pulse: outputs clear immediately (async), no pulse completes.
//  Coordinates: 10-bit unsigned; sums widened to 11 bits before compare; no wrap-around.
// CONFIGURATION
//  FORMACAO_TIRO_EN defined: adds ports tiro (out 1, 1-cycle pulse) and tiro_idx (out $clog2(N_INIM)).
//   - Every 4th passo/descer, a round-robin search from last_idx+1 picks the next alive enemy.
//   - tiro pulses one cycle after that step pulse.
//   - No alive enemy -> no tiro; last_idx resets to N_INIM-1.
//  FORMACAO_TIRO_EN undefined: those ports and that logic do not exist; all other behaviour identical.
// STRUCTURE
//  Package formacao_pkg: state encoding (ESPERA, AVALIA, MOVE, DESCE, FIM), screen/sprite constants, width of the divider.
//  Sub-module formacao_borda_det: combinational reduction over vivo/x/y producing borda_dir, borda_esq, invade.
//  Round-robin picker (only under FORMACAO_TIRO_EN) inline in formacao_ctrl.
// TESTING (DIV_BASE=10, DIV_DEC=2, DIV_MIN=4, N_INIM=4)
//  1 Reset, all vivo=1, x=100..400 -> first passo at cycle 11 after release, then every 11 cycles; sentido=0.
//  2 sentido=0, alive enemy at x=1 -> next AVALIA gives descer pulse, sentido=1, no passo that step.
//  3 vivo=4'b0011 -> P=6, passo every 7 cycles; vivo=0 -> P floor 4 never undercut, fim_onda=1 and pulses stop.
//  4 alive enemy y=416 (416+24=440) -> invasao=1 same evaluation; dead enemy at y=430 ignored.
//  5 pausa=1 for 50 cycles mid-ESPERA -> no pulses; on release the divider resumes from its held value.
//  6 FORMACAO_TIRO_EN, vivo=4'b1010 -> tiro_idx sequence 1,3,1 on every 4th step.

Source files
------------

// File: rtl/formacao_pkg.sv
// Shared definitions for the enemy formation sequencer: FSM state
// encoding, default screen/sprite geometry, divider width and the
// step-period helper.
package formacao_pkg;

    typedef enum logic [2:0] {
        ESPERA,
        AVALIA,
        MOVE,
        DESCE,
        FIM
    } estado_t;

    localparam int DIV_W        = 32;
    localparam int COORD_W      = 10;
    localparam int LARGURA_PAD  = 33;
    localparam int ALTURA_PAD   = 24;
    localparam int TELA_W_PAD   = 640;
    localparam int PASSO_X_PAD  = 2;
    localparam int LIMITE_Y_PAD = 440;

    // Step period max(minimo, base - dec*mortos), never underflowing.
    function automatic logic [DIV_W-1:0] calc_periodo(
        input logic [DIV_W-1:0] base,
        input logic [DIV_W-1:0] dec,
        input logic [DIV_W-1:0] minimo,
        input logic [3:0]       mortos
    );
        logic [DIV_W-1:0] reduz;
        reduz = dec * {{(DIV_W-4){1'b0}}, mortos};
        if (reduz >= base)
            return minimo;
        else if ((base - reduz) < minimo)
            return minimo;
        else
            return base - reduz;
    endfunction

endpackage

// File: rtl/formacao_borda_det.sv
// Combinational reduction over the formation: flags an alive enemy at the
// right edge, at the left edge, or touching the invasion line. Sums are
// widened to 11 bits so no coordinate can wrap.
module formacao_borda_det
    import formacao_pkg::*;
#(
    parameter int N_INIM   = 8,
    parameter int LARGURA  = LARGURA_PAD,
    parameter int ALTURA   = ALTURA_PAD,
    parameter int TELA_W   = TELA_W_PAD,
    parameter int PASSO_X  = PASSO_X_PAD,
    parameter int LIMITE_Y = LIMITE_Y_PAD
) (
    input  logic [N_INIM-1:0]         vivo,
    input  logic [COORD_W*N_INIM-1:0] x_flat,
    input  logic [COORD_W*N_INIM-1:0] y_flat,
    output logic                      borda_dir,
    output logic                      borda_esq,
    output logic                      invade
);

    logic [N_INIM-1:0] dir_v;
    logic [N_INIM-1:0] esq_v;
    logic [N_INIM-1:0] inv_v;

    for (genvar gi = 0; gi < N_INIM; gi++) begin : g_inim
        logic [COORD_W:0] x_ext;
        logic [COORD_W:0] y_ext;
        assign x_ext    = {1'b0, x_flat[COORD_W*gi +: COORD_W]};
        assign y_ext    = {1'b0, y_flat[COORD_W*gi +: COORD_W]};
        assign dir_v[gi] = vivo[gi] && ((x_ext + 11'(LARGURA + PASSO_X)) > 11'(TELA_W));
        assign esq_v[gi] = vivo[gi] && (x_ext < 11'(PASSO_X));
        assign inv_v[gi] = vivo[gi] && ((y_ext + 11'(ALTURA)) >= 11'(LIMITE_Y));
    end

    assign borda_dir = |dir_v;
    assign borda_esq = |esq_v;
    assign invade    = |inv_v;

endmodule

// File: rtl/formacao_ctrl.sv
// Enemy formation sequencer: divides CLOCK_50 into movement steps, keeps
// the shared direction, issues one-cycle passo/descer commands, speeds up
// as enemies die and raises sticky wave-cleared / invasion flags.
// Optional feature macro FORMACAO_TIRO_EN adds a round-robin shooter picker
// (ports tiro, tiro_idx) that fires after every 4th step.
module formacao_ctrl
    import formacao_pkg::*;
#(
    parameter int N_INIM   = 8,
    parameter int DIV_BASE = 320000,
    parameter int DIV_DEC  = 30000,
    parameter int DIV_MIN  = 80000,
    parameter int LARGURA  = LARGURA_PAD,
    parameter int ALTURA   = ALTURA_PAD,
    parameter int TELA_W   = TELA_W_PAD,
    parameter int PASSO_X  = PASSO_X_PAD,
    parameter int LIMITE_Y = LIMITE_Y_PAD
) (
    input  logic                      CLOCK_50,
    input  logic                      resetInimigo,
    input  logic                      pausa,
    input  logic [N_INIM-1:0]         vivo,
    input  logic [COORD_W*N_INIM-1:0] x_flat,
    input  logic [COORD_W*N_INIM-1:0] y_flat,
    output logic                      passo,
    output logic                      descer,
    output logic                      sentido,
    output logic                      fim_onda,
    output logic                      invasao,
    output logic [3:0]                n_mortos
`ifdef FORMACAO_TIRO_EN
    ,
    output logic                      tiro,
    output logic [((N_INIM > 1) ? $clog2(N_INIM) : 1)-1:0] tiro_idx
`endif
);

    estado_t          estado_reg, estado_next;
    logic [DIV_W-1:0] divider_reg, divider_next;
    logic             sentido_reg, sentido_next;
    logic             fim_onda_reg;
    logic             invasao_reg;
    logic [3:0]       n_mortos_reg;

    logic             borda_dir, borda_esq, invade;
    logic             borda;
    logic             fim_set;
    logic [DIV_W-1:0] periodo;
    logic [DIV_W-1:0] limite;
    int               mortos_cnt;
    logic [3:0]       mortos_sat;

    formacao_borda_det #(
        .N_INIM   (N_INIM),
        .LARGURA  (LARGURA),
        .ALTURA   (ALTURA),
        .TELA_W   (TELA_W),
        .PASSO_X  (PASSO_X),
        .LIMITE_Y (LIMITE_Y)
    ) u_borda (
        .vivo      (vivo),
        .x_flat    (x_flat),
        .y_flat    (y_flat),
        .borda_dir (borda_dir),
        .borda_esq (borda_esq),
        .invade    (invade)
    );

    assign borda   = sentido_reg ? borda_dir : borda_esq;
    assign fim_set = (vivo == '0);
    assign periodo = calc_periodo(DIV_W'(DIV_BASE), DIV_W'(DIV_DEC), DIV_W'(DIV_MIN), n_mortos_reg);
    assign limite  = periodo - 1'b1;

    // Count dead enemies, saturating at the 4-bit output range.
    always_comb begin
        mortos_cnt = 0;
        for (int i = 0; i < N_INIM; i++) begin
            if (!vivo[i])
                mortos_cnt = mortos_cnt + 1;
        end
        mortos_sat = (mortos_cnt > 15) ? 4'd15 : mortos_cnt[3:0];
    end

    // Next state: end-of-game wins over pause; pause freezes divider and state.
    // The pulse cycle reloads the divider with 1 so a full step is P+1 cycles.
    always_comb begin
        estado_next  = estado_reg;
        divider_next = divider_reg;
        sentido_next = sentido_reg;
        if (fim_onda_reg || invasao_reg || fim_set || invade) begin
            estado_next = FIM;
        end else if (!pausa) begin
            case (estado_reg)
                ESPERA: begin
                    if (divider_reg >= limite) begin
                        estado_next  = AVALIA;
                        divider_next = '0;
                    end else begin
                        divider_next = divider_reg + 1'b1;
                    end
                end
                AVALIA: begin
                    if (borda) begin
                        estado_next  = DESCE;
                        sentido_next = ~sentido_reg;
                    end else begin
                        estado_next = MOVE;
                    end
                end
                MOVE, DESCE: begin
                    estado_next  = ESPERA;
                    divider_next = DIV_W'(1);
                end
                default: estado_next = FIM;
            endcase
        end
    end

    // State, divider, direction and sticky status registers.
    always_ff @(posedge CLOCK_50 or posedge resetInimigo) begin
        if (resetInimigo) begin
            estado_reg   <= ESPERA;
            divider_reg  <= '0;
            sentido_reg  <= 1'b0;
            fim_onda_reg <= 1'b0;
            invasao_reg  <= 1'b0;
            n_mortos_reg <= 4'd0;
        end else begin
            estado_reg   <= estado_next;
            divider_reg  <= divider_next;
            sentido_reg  <= sentido_next;
            fim_onda_reg <= fim_onda_reg | fim_set;
            invasao_reg  <= invasao_reg | invade;
            n_mortos_reg <= mortos_sat;
        end
    end

    assign passo    = (estado_reg == MOVE)  && !pausa;
    assign descer   = (estado_reg == DESCE) && !pausa;
    assign sentido  = sentido_reg;
    assign fim_onda = fim_onda_reg;
    assign invasao  = invasao_reg;
    assign n_mortos = n_mortos_reg;

`ifdef FORMACAO_TIRO_EN
    localparam int IDX_W = (N_INIM > 1) ? $clog2(N_INIM) : 1;

    logic [1:0]       passos_reg;
    logic [IDX_W-1:0] last_idx_reg;
    logic [IDX_W-1:0] tiro_idx_reg;
    logic             tiro_reg;
    logic [IDX_W-1:0] escolhido;
    logic             achou;
    logic             step;
    int               cand;

    assign step = passo || descer;

    // Round-robin search for the first alive enemy after the last shooter.
    always_comb begin
        achou     = 1'b0;
        escolhido = last_idx_reg;
        cand      = 0;
        for (int k = 1; k <= N_INIM; k++) begin
            cand = int'(last_idx_reg) + k;
            if (cand >= N_INIM)
                cand = cand - N_INIM;
            if (!achou && vivo[IDX_W'(cand)]) begin
                achou     = 1'b1;
                escolhido = IDX_W'(cand);
            end
        end
    end

    // Fire one cycle after every 4th step pulse.
    always_ff @(posedge CLOCK_50 or posedge resetInimigo) begin
        if (resetInimigo) begin
            passos_reg   <= 2'd0;
            last_idx_reg <= IDX_W'(N_INIM - 1);
            tiro_idx_reg <= '0;
            tiro_reg     <= 1'b0;
        end else begin
            tiro_reg <= 1'b0;
            if (step) begin
                passos_reg <= passos_reg + 2'd1;
                if (passos_reg == 2'd3) begin
                    if (achou) begin
                        tiro_reg     <= 1'b1;
                        tiro_idx_reg <= escolhido;
                        last_idx_reg <= escolhido;
                    end else begin
                        last_idx_reg <= IDX_W'(N_INIM - 1);
                    end
                end
            end
        end
    end

    assign tiro     = tiro_reg;
    assign tiro_idx = tiro_idx_reg;
`endif

endmodule
